// File: rtl/sonar_rx_pkg.sv
// Shared constants and types for the sonar serial word receiver.
// Provides default widths/timeouts and the receive FSM state type.
package sonar_rx_pkg;

   localparam int unsigned DEF_WORD_WIDTH  = 32;
   localparam int unsigned DEF_ADDR_WIDTH  = 12;
   localparam int unsigned DEF_SYNC_STAGES = 2;
   localparam int unsigned DEF_TIMEOUT_CYC = 1024;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } rx_state_t;

endpackage

// File: rtl/strobe_sync.sv
// Two-bit synchroniser (strobe, data) with registered rising-edge pulse.
// Ports: clk, reset_n (async low), clear (sync), strobe_i/data_i (async),
//        edge_o (1-clk pulse), bit_o (data sampled alongside the edge).
module strobe_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic strobe_i,
   input  logic data_i,
   output logic edge_o,
   output logic bit_o
);

   logic [SYNC_STAGES-1:0] stb_q;
   logic [SYNC_STAGES-1:0] dat_q;
   logic                   stb_prev_q;
   logic                   edge_q;
   logic                   bit_q;

   // Data runs through an identical chain so it stays aligned with the
   // strobe; both are registered once more with the edge pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stb_q      <= '0;
         dat_q      <= '0;
         stb_prev_q <= 1'b0;
         edge_q     <= 1'b0;
         bit_q      <= 1'b0;
      end else if (clear) begin
         stb_q      <= '0;
         dat_q      <= '0;
         stb_prev_q <= 1'b0;
         edge_q     <= 1'b0;
         bit_q      <= 1'b0;
      end else begin
         stb_q      <= {stb_q[SYNC_STAGES-2:0], strobe_i};
         dat_q      <= {dat_q[SYNC_STAGES-2:0], data_i};
         stb_prev_q <= stb_q[SYNC_STAGES-1];
         edge_q     <= stb_q[SYNC_STAGES-1] & ~stb_prev_q;
         bit_q      <= dat_q[SYNC_STAGES-1];
      end
   end

   assign edge_o = edge_q;
   assign bit_o  = bit_q;

endmodule

// File: rtl/serial_word_receiver_p.sv
// Serial-to-parallel word receiver with valid/ack handoff and address count.
// Ports: clk, reset_n, clear, data_strobe, data_pin, word_out, word_addr,
//        word_valid, word_ack, overrun (sticky), frame_error (1-clk pulse).
module serial_word_receiver_p
   import sonar_rx_pkg::*;
#(
   parameter int unsigned WORD_WIDTH  = DEF_WORD_WIDTH,
   parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int unsigned MSB_FIRST   = 0,
   parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clear,
   input  logic                  data_strobe,
   input  logic                  data_pin,
   output logic [WORD_WIDTH-1:0] word_out,
   output logic [ADDR_WIDTH-1:0] word_addr,
   output logic                  word_valid,
   input  logic                  word_ack,
   output logic                  overrun,
   output logic                  frame_error
);

   localparam int unsigned CW = $clog2(WORD_WIDTH);
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

   logic edge_s;
   logic bit_s;

   strobe_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear    (clear),
      .strobe_i (data_strobe),
      .data_i   (data_pin),
      .edge_o   (edge_s),
      .bit_o    (bit_s)
   );

   rx_state_t             state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [WORD_WIDTH-1:0] sh_q, sh_d;
   logic [TW-1:0]         to_q, to_d;
   logic [WORD_WIDTH-1:0] word_q, word_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH-1:0] nxt_q, nxt_d;
   logic                  valid_q, valid_d;
   logic                  ovr_q, ovr_d;
   logic                  ferr_q, ferr_d;

   logic [WORD_WIDTH-1:0] sh_n;
   logic                  last;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sh_q    <= '0;
         to_q    <= '0;
         word_q  <= '0;
         addr_q  <= '0;
         nxt_q   <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
         ferr_q  <= 1'b0;
      end else if (clear) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sh_q    <= '0;
         to_q    <= '0;
         word_q  <= '0;
         addr_q  <= '0;
         nxt_q   <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         to_q    <= to_d;
         word_q  <= word_d;
         addr_q  <= addr_d;
         nxt_q   <= nxt_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
         ferr_q  <= ferr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      to_d    = to_q;
      word_d  = word_q;
      addr_d  = addr_q;
      nxt_d   = nxt_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      ferr_d  = 1'b0;

      if (MSB_FIRST != 0) begin
         sh_n = {sh_q[WORD_WIDTH-2:0], bit_s};
      end else begin
         sh_n = {bit_s, sh_q[WORD_WIDTH-1:1]};
      end
      last = (cnt_q == CW'(WORD_WIDTH - 1));

      if (valid_q && word_ack) begin
         valid_d = 1'b0;
      end

      if (edge_s) begin
         // An edge always wins over a coincident timeout.
         to_d = '0;
         sh_d = sh_n;
         if (last) begin
            cnt_d   = '0;
            state_d = IDLE;
            if (!valid_q || word_ack) begin
               word_d  = sh_n;
               addr_d  = nxt_q;
               valid_d = 1'b1;
               nxt_d   = nxt_q + 1'b1;
            end else begin
               ovr_d = 1'b1;
            end
         end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = SHIFT;
         end
      end else begin
         unique case (state_q)
            SHIFT: begin
               if (to_q == TW'(TIMEOUT_CYC - 1)) begin
                  to_d    = '0;
                  cnt_d   = '0;
                  sh_d    = '0;
                  ferr_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  to_d = to_q + 1'b1;
               end
            end
            default: begin
               to_d = '0;
            end
         endcase
      end
   end

   assign word_out    = word_q;
   assign word_addr   = addr_q;
   assign word_valid  = valid_q;
   assign overrun     = ovr_q;
   assign frame_error = ferr_q;

endmodule

// File: tb/tb_serial_word_receiver_p.sv
// Directed bench for serial_word_receiver_p: two configurations
// (32-bit LSB-first, 8-bit MSB-first with 2-bit address).
module tb_serial_word_receiver_p;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n, clear_a, clear_b;
   logic stb_a, pin_a, ack_a, stb_b, pin_b, ack_b;
   logic [31:0] wo_a;
   logic [11:0] wa_a;
   logic        v_a, ov_a, fe_a;
   logic [7:0]  wo_b;
   logic [1:0]  wa_b;
   logic        v_b, ov_b, fe_b;

   serial_word_receiver_p #(
      .WORD_WIDTH(32), .ADDR_WIDTH(12), .MSB_FIRST(0),
      .SYNC_STAGES(2), .TIMEOUT_CYC(16)
   ) dut_a (
      .clk(clk), .reset_n(reset_n), .clear(clear_a),
      .data_strobe(stb_a), .data_pin(pin_a),
      .word_out(wo_a), .word_addr(wa_a), .word_valid(v_a),
      .word_ack(ack_a), .overrun(ov_a), .frame_error(fe_a)
   );

   serial_word_receiver_p #(
      .WORD_WIDTH(8), .ADDR_WIDTH(2), .MSB_FIRST(1),
      .SYNC_STAGES(3), .TIMEOUT_CYC(8)
   ) dut_b (
      .clk(clk), .reset_n(reset_n), .clear(clear_b),
      .data_strobe(stb_b), .data_pin(pin_b),
      .word_out(wo_b), .word_addr(wa_b), .word_valid(v_b),
      .word_ack(ack_b), .overrun(ov_b), .frame_error(fe_b)
   );

   typedef struct {
      logic [31:0] data;
      int          addr;
   } vec_t;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] qw_a[$];
   int          qa_a[$];
   logic [31:0] qw_b[$];
   int          qa_b[$];

   // Record every accepted transfer (valid & ack).
   always @(negedge clk) begin
      if (v_a && ack_a) begin
         qw_a.push_back(wo_a);
         qa_a.push_back(int'(wa_a));
      end
      if (v_b && ack_b) begin
         qw_b.push_back(32'(wo_b));
         qa_b.push_back(int'(wa_b));
      end
   end

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bits(bit sel, logic [31:0] v, int n, int w, bit msb);
      for (int i = 0; i < n; i++) begin
         logic b;
         b = msb ? v[w-1-i] : v[i];
         if (sel) begin stb_b = 1'b0; pin_b = b; end
         else     begin stb_a = 1'b0; pin_a = b; end
         tick(3);
         if (sel) stb_b = 1'b1;
         else     stb_a = 1'b1;
         tick(3);
      end
      if (sel) stb_b = 1'b0;
      else     stb_a = 1'b0;
      tick(6);
   endtask

   task automatic expect_a(string nm, logic [31:0] w, int a);
      check({nm, " count"}, 32'(qw_a.size()), 32'd1);
      if (qw_a.size() > 0) begin
         check({nm, " word"}, qw_a.pop_front(), w);
         check({nm, " addr"}, 32'(qa_a.pop_front()), 32'(a));
      end
      qw_a.delete();
      qa_a.delete();
   endtask

   task automatic expect_b(string nm, logic [31:0] w, int a);
      check({nm, " count"}, 32'(qw_b.size()), 32'd1);
      if (qw_b.size() > 0) begin
         check({nm, " word"}, qw_b.pop_front(), w);
         check({nm, " addr"}, 32'(qa_b.pop_front()), 32'(a));
      end
      qw_b.delete();
      qa_b.delete();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t tv_a[5];
      vec_t tv_b[5];
      int   hi;

      tv_a[0] = '{32'hDEADBEEF, 0};
      tv_a[1] = '{32'h00000001, 1};
      tv_a[2] = '{32'h80000000, 2};
      tv_a[3] = '{32'hFFFFFFFF, 3};
      tv_a[4] = '{32'h0F0F00FF, 4};
      tv_b[0] = '{32'h000000A5, 0};
      tv_b[1] = '{32'h00000001, 1};
      tv_b[2] = '{32'h00000080, 2};
      tv_b[3] = '{32'h0000001E, 3};
      tv_b[4] = '{32'h0000006A, 0};

      reset_n = 1'b0;
      clear_a = 1'b0; clear_b = 1'b0;
      stb_a = 1'b0; pin_a = 1'b0; ack_a = 1'b0;
      stb_b = 1'b0; pin_b = 1'b0; ack_b = 1'b0;
      tick(3);
      check("rst word_out", wo_a, 32'h0);
      check("rst word_addr", 32'(wa_a), 32'h0);
      check("rst valid", 32'(v_a), 32'h0);
      check("rst overrun", 32'(ov_a), 32'h0);
      check("rst frame_error", 32'(fe_a), 32'h0);
      check("rst valid b", 32'(v_b), 32'h0);
      reset_n = 1'b1;
      tick(2);

      ack_a = 1'b1;
      ack_b = 1'b1;
      for (int i = 0; i < 5; i++) begin
         send_bits(1'b0, tv_a[i].data, 32, 32, 1'b0);
         expect_a($sformatf("lsb vec%0d", i), tv_a[i].data, tv_a[i].addr);
         check($sformatf("lsb vec%0d valid low", i), 32'(v_a), 32'h0);
      end
      for (int i = 0; i < 5; i++) begin
         send_bits(1'b1, tv_b[i].data, 8, 8, 1'b1);
         expect_b($sformatf("msb vec%0d", i), tv_b[i].data, tv_b[i].addr);
      end

      // No ack: overrun, hold, then ack and next address.
      clear_a = 1'b1;
      tick(1);
      clear_a = 1'b0;
      check("clear word_out", wo_a, 32'h0);
      ack_a = 1'b0;
      send_bits(1'b0, 32'h11111111, 32, 32, 1'b0);
      check("hold1 valid", 32'(v_a), 32'h1);
      check("hold1 word", wo_a, 32'h11111111);
      check("hold1 addr", 32'(wa_a), 32'h0);
      check("hold1 overrun", 32'(ov_a), 32'h0);
      send_bits(1'b0, 32'h22222222, 32, 32, 1'b0);
      check("ovr valid", 32'(v_a), 32'h1);
      check("ovr word", wo_a, 32'h11111111);
      check("ovr addr", 32'(wa_a), 32'h0);
      check("ovr overrun", 32'(ov_a), 32'h1);
      ack_a = 1'b1;
      tick(1);
      ack_a = 1'b0;
      check("ack valid low", 32'(v_a), 32'h0);
      expect_a("ack take", 32'h11111111, 0);
      ack_a = 1'b1;
      send_bits(1'b0, 32'h33333333, 32, 32, 1'b0);
      expect_a("after ovr", 32'h33333333, 1);
      check("ovr sticky", 32'(ov_a), 32'h1);

      // Partial word then timeout.
      send_bits(1'b0, 32'h00000015, 5, 32, 1'b0);
      hi = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (fe_a) hi++;
      end
      check("frame_error pulses", 32'(hi), 32'h1);
      check("timeout no word", 32'(qw_a.size()), 32'h0);
      tick(1);
      send_bits(1'b0, 32'h12345678, 32, 32, 1'b0);
      expect_a("post timeout", 32'h12345678, 2);

      // Reset mid-word.
      send_bits(1'b0, 32'h000003FF, 10, 32, 1'b0);
      reset_n = 1'b0;
      tick(2);
      check("mid rst valid", 32'(v_a), 32'h0);
      check("mid rst overrun", 32'(ov_a), 32'h0);
      reset_n = 1'b1;
      tick(2);
      send_bits(1'b0, 32'hCAFEF00D, 32, 32, 1'b0);
      expect_a("post reset", 32'hCAFEF00D, 0);
      check("post reset overrun", 32'(ov_a), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
